// File: rtl/button_debounce_if.sv
// rtl/button_debounce_if.sv - raw button input, glitch clear and debounced outputs
interface button_debounce_if;
  logic       ibutton_raw;
  logic       iclr_glitch;
  logic       obutton;
  logic       obusy;
  logic [7:0] o_glitch_cnt;

  modport master (
    output ibutton_raw,
    output iclr_glitch,
    input  obutton,
    input  obusy,
    input  o_glitch_cnt
  );

  modport slave (
    input  ibutton_raw,
    input  iclr_glitch,
    output obutton,
    output obusy,
    output o_glitch_cnt
  );
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronizing button debouncer with glitch counter
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input logic               iclk,
  input logic               irst,
  button_debounce_if.slave  bus
);

  localparam logic        INACTIVE_RAW = ACTIVE_LOW;
  localparam logic [15:0] CNT_LAST     = 16'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  sync_q;
  logic [7:0]  glitch_q, glitch_d;
  logic        obutton_q, obusy_q;
  logic        abort;
  logic        s;

  // Reset loads the idle raw level so leaving reset never looks like a press.
  always_ff @(posedge iclk) begin
    if (irst) begin
      sync_q <= {2{INACTIVE_RAW}};
    end else begin
      sync_q <= {sync_q[0], bus.ibutton_raw};
    end
  end

  assign s = sync_q[1] ^ ACTIVE_LOW;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear in the same cycle as an abort wins; the count saturates at 255.
  always_comb begin
    glitch_d = glitch_q;
    if (bus.iclr_glitch) begin
      glitch_d = '0;
    end else if (abort && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      glitch_q  <= '0;
      obutton_q <= 1'b0;
      obusy_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      glitch_q  <= glitch_d;
      obutton_q <= (state_q == PRESSED) || (state_q == RELEASE_WAIT);
      obusy_q   <= (state_q == PRESS_WAIT) || (state_q == RELEASE_WAIT);
    end
  end

  assign bus.obutton      = obutton_q;
  assign bus.obusy        = obusy_q;
  assign bus.o_glitch_cnt = glitch_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - randomized and directed checks of button_debounce against a run-length model
module tb_button_debounce;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw = 1'b0;
  logic clr = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rises = 0;
  logic prev_btn = 1'b0;

  always #5 clk = ~clk;

  button_debounce_if bus0 ();
  button_debounce_if bus1 ();

  assign bus0.ibutton_raw = raw;
  assign bus0.iclr_glitch = clr;
  assign bus1.ibutton_raw = ~raw;
  assign bus1.iclr_glitch = clr;

  button_debounce #(.DEBOUNCE_CYC(D), .ACTIVE_LOW(1'b0)) dut_hi (
    .iclk(clk), .irst(rst), .bus(bus0)
  );

  button_debounce #(.DEBOUNCE_CYC(D), .ACTIVE_LOW(1'b1)) dut_lo (
    .iclk(clk), .irst(rst), .bus(bus1)
  );

  // Model: the level flips once s has differed from it for D+1 consecutive
  // FSM edges; a run that ends early is one glitch. s lags raw by two edges.
  bit m_sh1 = 1'b0, m_sh2 = 1'b0, m_lvl = 1'b0;
  int m_run = 0;
  bit e_btn = 1'b0, e_busy = 1'b0;
  int e_gl = 0;

  always @(posedge clk) begin
    automatic bit s   = m_sh2;
    automatic bit lvl = m_lvl;
    automatic int run = m_run;
    automatic int gl  = e_gl;
    automatic bit ab  = 1'b0;
    cyc <= cyc + 1;
    if (rst) begin
      m_sh1 <= 1'b0; m_sh2 <= 1'b0; m_lvl <= 1'b0; m_run <= 0;
      e_btn <= 1'b0; e_busy <= 1'b0; e_gl <= 0;
    end else begin
      e_btn  <= lvl;
      e_busy <= (run > 0);
      if (s != lvl) begin
        run++;
        if (run == D + 1) begin
          lvl = s;
          run = 0;
        end
      end else begin
        if (run > 0) ab = 1'b1;
        run = 0;
      end
      if (clr) gl = 0;
      else if (ab && gl < 255) gl++;
      m_lvl <= lvl; m_run <= run; e_gl <= gl;
      m_sh2 <= m_sh1; m_sh1 <= raw;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("hi_obutton", int'(bus0.obutton), int'(e_btn));
      chk("hi_obusy", int'(bus0.obusy), int'(e_busy));
      chk("hi_glitch", int'(bus0.o_glitch_cnt), e_gl);
      chk("lo_obutton", int'(bus1.obutton), int'(e_btn));
      chk("lo_obusy", int'(bus1.obusy), int'(e_busy));
      chk("lo_glitch", int'(bus1.o_glitch_cnt), e_gl);
      if (bus0.obutton && !prev_btn) rises++;
      prev_btn = bus0.obutton;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int e0, e1, r0;
    step(3);
    chk("reset_obutton", int'(bus0.obutton), 0);
    chk("reset_obusy", int'(bus0.obusy), 0);
    chk("reset_glitch", int'(bus0.o_glitch_cnt), 0);
    rst = 1'b0;
    step(5);
    chk("lo_idle_after_reset", int'(bus1.obutton), 0);

    // Clean press: first sample at e0, busy edges 3..10, rise at edge 11.
    raw = 1'b1;
    step(1);
    e0 = cyc;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (cyc - e0 == 2) chk("press_busy_e2", int'(bus0.obusy), 0);
      if (cyc - e0 == 3) chk("press_busy_e3", int'(bus0.obusy), 1);
      if (cyc - e0 == 10) chk("press_btn_e10", int'(bus0.obutton), 0);
      if (cyc - e0 == 11) begin
        chk("press_btn_e11", int'(bus0.obutton), 1);
        chk("press_busy_e11", int'(bus0.obusy), 0);
        chk("lo_press_btn_e11", int'(bus1.obutton), 1);
        chk("model_btn_e11", int'(e_btn), 1);
      end
    end
    step(17);
    raw = 1'b0;
    step(1);
    e1 = cyc;
    step(10);
    chk("release_btn_e10", int'(bus0.obutton), 1);
    step(1);
    chk("release_btn_e11", int'(bus0.obutton), 0);
    chk("release_glitch", int'(bus0.o_glitch_cnt), 0);
    step(5);

    // Three-cycle glitch
    raw = 1'b1;
    step(3);
    raw = 1'b0;
    step(20);
    chk("glitch_count", int'(bus0.o_glitch_cnt), 1);
    chk("model_glitch_count", e_gl, 1);
    chk("glitch_btn", int'(bus0.obutton), 0);

    // Bounce 1,0,1,0 at two-cycle spacing, then hold
    rises = 0;
    for (int k = 0; k < 2; k++) begin
      raw = 1'b1; step(2);
      raw = 1'b0; step(2);
    end
    raw = 1'b1;
    step(1);
    e1 = cyc;
    step(10);
    chk("bounce_btn_e10", int'(bus0.obutton), 0);
    step(1);
    chk("bounce_btn_e11", int'(bus0.obutton), 1);
    step(5);
    chk("bounce_glitch", int'(bus0.o_glitch_cnt), 3);
    chk("bounce_rises", rises, 1);

    // Reset while PRESSED with the button held
    rst = 1'b1;
    step(1);
    r0 = cyc;
    chk("midreset_btn", int'(bus0.obutton), 0);
    rst = 1'b0;
    step(11);
    chk("requal_btn_r11", int'(bus0.obutton), 0);
    step(1);
    chk("requal_btn_r12", int'(bus0.obutton), 1);
    chk("requal_glitch", int'(bus0.o_glitch_cnt), 0);
    raw = 1'b0;
    step(20);

    // 300 glitches saturate the counter, then clear coincident with an abort
    for (int k = 0; k < 300; k++) begin
      raw = 1'b1; step(2);
      raw = 1'b0; step(2);
    end
    step(10);
    chk("sat_glitch", int'(bus0.o_glitch_cnt), 255);
    raw = 1'b1; step(2);
    raw = 1'b0; step(2);
    clr = 1'b1; step(1);
    clr = 1'b0;
    chk("clear_wins", int'(bus0.o_glitch_cnt), 0);
    step(5);

    // Random runs with occasional clear and reset
    for (int n = 0; n < 400; n++) begin
      int len;
      raw = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        clr = ($urandom_range(0, 31) == 0);
        rst = ($urandom_range(0, 299) == 0);
        step(1);
      end
    end
    clr = 1'b0;
    rst = 1'b0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 50000, the number of consecutive stable cycles needed to accept a level change; legal values are 2..65535.
REQ-002 SHALL have parameter ACTIVE_LOW, default 1; when 1, a raw input level of 0 means "pressed".
REQ-003 SHALL have port iclk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port irst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port ibutton_raw, input, 1 bit: the asynchronous mechanical button or contact input.
REQ-006 SHALL have port iclr_glitch, input, 1 bit: a one-cycle pulse that clears the glitch counter.
REQ-007 SHALL have port obutton, output, 1 bit: the debounced active-high level, which feeds the downstream strobe-cutter's ibutton.
REQ-008 SHALL have port obusy, output, 1 bit: high while a level change is being qualified.
REQ-009 SHALL have port o_glitch_cnt, output, 8 bits: a saturating count of rejected transitions.

Function
REQ-010 SHALL pass ibutton_raw through a two-flop synchronizer before any other use.
REQ-011 SHALL normalise the synchronized value to s, where s = 1 means pressed, taking ACTIVE_LOW into account.
REQ-012 SHALL implement an FSM with four states: IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-013 In IDLE: if s=1, go to PRESS_WAIT and clear the 16-bit counter cnt to 0; otherwise stay.
REQ-014 In PRESS_WAIT with s=1: if cnt==DEBOUNCE_CYC-1, go to PRESSED; otherwise increment cnt.
REQ-015 In PRESS_WAIT with s=0: return to IDLE and count one glitch.
REQ-016 In PRESSED: if s=0, go to RELEASE_WAIT and clear cnt to 0; otherwise stay.
REQ-017 In RELEASE_WAIT with s=0: if cnt==DEBOUNCE_CYC-1, go to IDLE; otherwise increment cnt.
REQ-018 In RELEASE_WAIT with s=1: return to PRESSED and count one glitch.
REQ-019 SHALL register obutton so that it is 1 exactly when the state is PRESSED or RELEASE_WAIT.
REQ-020 SHALL register obusy so that it is 1 exactly when the state is PRESS_WAIT or RELEASE_WAIT.
REQ-021 Press latency SHALL be as follows: with the raw input stable and first sampled pressed at edge 0, obutton rises at edge DEBOUNCE_CYC+3.
REQ-022 Release latency SHALL be the same: obutton falls at edge DEBOUNCE_CYC+3 after the first sampled release.
REQ-023 Any change in s during a WAIT state SHALL abort qualification; a new qualification restarts from cnt=0 with no partial credit.
REQ-024 o_glitch_cnt SHALL increment by 1 per abort and saturate at 255 without wrapping.
REQ-025 When iclr_glitch and an abort occur in the same cycle, the clear SHALL win and o_glitch_cnt SHALL become 0.
REQ-026 cnt SHALL never exceed DEBOUNCE_CYC-1 and SHALL never wrap.
REQ-027 obutton SHALL change at most once per DEBOUNCE_CYC+1 cycles.
REQ-028 obutton SHALL produce no single-cycle pulses.

Reset
REQ-029 While irst=1 at a clock edge, the block SHALL load: state IDLE, cnt 0, obutton 0, obusy 0, o_glitch_cnt 0.
REQ-030 During reset, both synchronizer flops SHALL load the inactive raw level (1 if ACTIVE_LOW, else 0), so that reset release can never produce a false press.
REQ-031 Reset asserted mid-operation, in any state, SHALL force obutton to 0 at the next edge.
REQ-032 If the button is still held after reset is released, it SHALL be re-qualified as a fresh press with full latency.
REQ-033 iclr_glitch SHALL be ignored while irst=1.

Verification
All scenarios use DEBOUNCE_CYC=8 and ACTIVE_LOW=0 unless stated.
REQ-034 Clean press: raw held at 1 for 30 cycles -> obutton rises at edge 11; obusy is high for edges 3..10; o_glitch_cnt stays 0. Then release raw -> obutton falls 11 edges after the first sampled 0.
REQ-035 Glitch: a raw high pulse of 3 cycles -> obutton stays 0 throughout; o_glitch_cnt=1; state returns to IDLE.
REQ-036 Bounce: raw toggles 1,0,1,0 with 2-cycle spacing, then holds 1 -> o_glitch_cnt=2; obutton rises 11 edges after the final rising sample; downstream sees exactly one rising edge.
REQ-037 Reset mid-press: irst pulsed for 1 cycle while in PRESSED with raw held at 1 -> obutton=0 at the next edge; obutton rises again 11 edges after irst falls.
REQ-038 Saturation and clear: 300 consecutive glitches -> o_glitch_cnt=255. Then iclr_glitch coincident with another glitch -> o_glitch_cnt=0.
REQ-039 Polarity: ACTIVE_LOW=1 with raw held at 1 through and after reset -> obutton=0 and obusy=0 indefinitely. Then raw held at 0 -> obutton rises at edge 11.
